// File: rtl/core.sv
// Real-mode 16-bit processor subset with a byte-wide bus and one memory access per enabled clock.
// Bus outputs are decoded from registered state only, and the write strobe is gated so no write lands on a reset edge.
module core #(
   parameter logic [15:0] RESET_IP = 16'h0100
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ce,
   output logic [19:0] a,
   input  logic [7:0]  i,
   output logic [7:0]  o,
   output logic        w,
   input  logic        intr,
   input  logic [7:0]  intn,
   output logic [3:0]  o_dbg_state
);
   typedef enum logic [3:0] {
      S_FETCH, S_IMM, S_EXEC, S_MEMRD, S_MEMWR, S_PUSH, S_POP, S_INT, S_HALT
   } state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [7:0]  r_op;
   logic [7:0]  r_vec;
   logic        r_intseq;
   logic [15:0] r_imm;
   logic [15:0] r_tmp;
   logic [15:0] r_gpr [8];
   logic [15:0] r_ip, r_cs, r_ds, r_ss;
   logic        r_zf, r_sf, r_if;

   logic [15:0] w_flags, w_sp, w_sp_dec, w_push_word, w_word, w_incdec, w_ip_exec;
   logic [15:0] w_disp8;
   logic [7:0]  w_push_byte;
   logic        w_if_exec, w_wr, w_imm_last;

   function automatic logic [19:0] lin(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'h0} + {4'h0, off};
   endfunction

   function automatic logic [1:0] imm_len(input logic [7:0] op);
      casez (op)
         8'b1011_0???, 8'hEB, 8'h74, 8'h75, 8'hCD: return 2'd1;
         8'b1011_1???, 8'hA0, 8'hA2, 8'hE9:        return 2'd2;
         default:                                  return 2'd0;
      endcase
   endfunction

   assign w_flags     = {6'b0, r_if, 1'b0, r_sf, r_zf, 4'b0, 1'b1, 1'b0};
   assign w_sp        = r_gpr[4];
   assign w_sp_dec    = w_sp - 16'd1;
   assign w_word      = {i, r_tmp[7:0]};
   assign w_incdec    = r_gpr[r_op[2:0]] + (r_op[3] ? 16'hFFFF : 16'h0001);
   assign w_disp8     = {{8{r_imm[7]}}, r_imm[7:0]};
   assign w_imm_last  = (imm_len(r_op) == 2'd1) || r_cnt[0];
   assign w_if_exec   = (r_op == 8'hFB) ? 1'b1 : (r_op == 8'hFA) ? 1'b0 : r_if;
   assign o_dbg_state = r_state;

   // Interrupt frames push FLAGS, CS, IP high byte first; PUSH r16 pushes the word latched at fetch.
   always_comb begin
      w_push_word = r_tmp;
      if (r_intseq) begin
         case (r_cnt[2:1])
            2'd0:    w_push_word = w_flags;
            2'd1:    w_push_word = r_cs;
            default: w_push_word = r_ip;
         endcase
      end
      w_push_byte = r_cnt[0] ? w_push_word[7:0] : w_push_word[15:8];
   end

   always_comb begin
      w_ip_exec = r_ip;
      case (r_op)
         8'hEB:   w_ip_exec = r_ip + w_disp8;
         8'hE9:   w_ip_exec = r_ip + r_imm;
         8'h74:   if (r_zf)  w_ip_exec = r_ip + w_disp8;
         8'h75:   if (!r_zf) w_ip_exec = r_ip + w_disp8;
         default: w_ip_exec = r_ip;
      endcase
   end

   always_comb begin
      a    = lin(r_cs, r_ip);
      o    = 8'h00;
      w_wr = 1'b0;
      case (r_state)
         S_MEMRD: a = lin(r_ds, r_imm);
         S_MEMWR: begin a = lin(r_ds, r_imm); o = r_gpr[0][7:0]; w_wr = 1'b1; end
         S_PUSH:  begin a = lin(r_ss, w_sp_dec); o = w_push_byte; w_wr = 1'b1; end
         S_POP:   a = lin(r_ss, w_sp);
         S_INT:   a = {10'b0, r_vec, r_cnt[1:0]};
         default: a = lin(r_cs, r_ip);
      endcase
   end

   assign w = w_wr & ~reset_n;

   always_ff @(posedge clock) begin
      if (reset_n) begin
         r_state  <= S_FETCH;
         r_cnt    <= '0;
         r_op     <= 8'h90;
         r_vec    <= '0;
         r_intseq <= 1'b0;
         r_imm    <= '0;
         r_tmp    <= '0;
         for (int k = 0; k < 8; k++) r_gpr[k] <= '0;
         r_ip     <= RESET_IP;
         r_cs     <= '0;
         r_ds     <= '0;
         r_ss     <= '0;
         r_zf     <= 1'b0;
         r_sf     <= 1'b0;
         r_if     <= 1'b0;
      end else if (ce) begin
         case (r_state)
            S_FETCH: begin
               r_op     <= i;
               r_ip     <= r_ip + 16'd1;
               r_cnt    <= '0;
               r_tmp    <= r_gpr[i[2:0]];
               r_intseq <= 1'b0;
               if (imm_len(i) != 2'd0)                   r_state <= S_IMM;
               else if (i[7:3] == 5'b01010)              r_state <= S_PUSH;
               else if (i[7:3] == 5'b01011 || i == 8'hCF) r_state <= S_POP;
               else if (i == 8'hCC) begin
                  r_vec    <= 8'd3;
                  r_intseq <= 1'b1;
                  r_state  <= S_PUSH;
               end else                                  r_state <= S_EXEC;
            end
            S_IMM: begin
               r_ip  <= r_ip + 16'd1;
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt[0]) r_imm[15:8] <= i;
               else          r_imm[7:0]  <= i;
               if (w_imm_last) begin
                  r_cnt <= '0;
                  case (r_op)
                     8'hA0:   r_state <= S_MEMRD;
                     8'hA2:   r_state <= S_MEMWR;
                     8'hCD: begin
                        r_vec    <= i;
                        r_intseq <= 1'b1;
                        r_state  <= S_PUSH;
                     end
                     default: r_state <= S_EXEC;
                  endcase
               end
            end
            S_MEMRD: begin
               r_gpr[0][7:0] <= i;
               r_state       <= S_EXEC;
            end
            S_MEMWR: r_state <= S_EXEC;
            S_PUSH: begin
               r_gpr[4] <= w_sp_dec;
               r_cnt    <= r_cnt + 3'd1;
               if (r_intseq ? (r_cnt == 3'd5) : (r_cnt == 3'd1)) begin
                  r_cnt <= '0;
                  if (r_intseq) begin
                     r_if    <= 1'b0;
                     r_state <= S_INT;
                  end else r_state <= S_EXEC;
               end
            end
            S_POP: begin
               r_gpr[4] <= w_sp + 16'd1;
               r_cnt    <= r_cnt + 3'd1;
               if (!r_cnt[0]) r_tmp[7:0] <= i;
               else if (r_op == 8'hCF) begin
                  case (r_cnt)
                     3'd1:    r_ip <= w_word;
                     3'd3:    r_cs <= w_word;
                     default: begin
                        r_zf <= w_word[6];
                        r_sf <= w_word[7];
                        r_if <= w_word[9];
                     end
                  endcase
               end else r_gpr[r_op[2:0]] <= w_word;  // after the SP update so POP SP keeps the popped value
               if ((r_op == 8'hCF) ? (r_cnt == 3'd5) : (r_cnt == 3'd1)) r_state <= S_EXEC;
            end
            S_INT: begin
               r_cnt <= r_cnt + 3'd1;
               case (r_cnt[1:0])
                  2'd0:    r_ip[7:0]  <= i;
                  2'd1:    r_ip[15:8] <= i;
                  2'd2:    r_cs[7:0]  <= i;
                  default: r_cs[15:8] <= i;
               endcase
               if (r_cnt[1:0] == 2'd3) r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_intseq <= 1'b0;
               r_ip     <= w_ip_exec;
               r_if     <= w_if_exec;
               casez (r_op)
                  8'b1011_0???: begin
                     if (r_op[2]) r_gpr[{1'b0, r_op[1:0]}][15:8] <= r_imm[7:0];
                     else         r_gpr[{1'b0, r_op[1:0]}][7:0]  <= r_imm[7:0];
                  end
                  8'b1011_1???: r_gpr[r_op[2:0]] <= r_imm;
                  8'b0100_????: begin
                     r_gpr[r_op[2:0]] <= w_incdec;
                     r_zf             <= (w_incdec == 16'h0000);
                     r_sf             <= w_incdec[15];
                  end
                  default: ;
               endcase
               // Instruction boundary: a pending interrupt wins over the next fetch.
               if (r_op == 8'hF4) r_state <= S_HALT;
               else if (intr && w_if_exec) begin
                  r_state  <= S_PUSH;
                  r_intseq <= 1'b1;
                  r_vec    <= intn;
                  r_cnt    <= '0;
                  r_op     <= 8'h90;
               end else r_state <= S_FETCH;
            end
            S_HALT: begin
               if (intr && r_if) begin
                  r_state  <= S_PUSH;
                  r_intseq <= 1'b1;
                  r_vec    <= intn;
                  r_cnt    <= '0;
                  r_op     <= 8'h90;
               end
            end
            default: r_state <= S_FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_core.sv
// Bench for core: byte memory model plus a per-clock bus-cycle scoreboard of {w, a, o}.
module tb_core;
   logic        clock = 1'b0;
   logic        reset_n, ce, intr, w;
   logic [7:0]  intn, i, o;
   logic [19:0] a;
   logic [3:0]  dbg_state;

   logic        tb_we;
   logic [19:0] tb_addr;
   logic [7:0]  tb_data;
   logic [7:0]  mem [0:1048575];

   logic [28:0] exp_q[$];
   int          n_chk = 0;
   int          n_bad = 0;

   core #(.RESET_IP(16'h0100)) dut (
      .clock(clock), .reset_n(reset_n), .ce(ce), .a(a), .i(i), .o(o), .w(w),
      .intr(intr), .intn(intn), .o_dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (tb_we)       mem[tb_addr] <= tb_data;
      else if (w && ce) mem[a]      <= o;
   end
   assign i = mem[a];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [19:0] ad, input logic [7:0] d);
      tb_we = 1'b1; tb_addr = ad; tb_data = d;
      @(negedge clock);
      tb_we = 1'b0;
   endtask

   // bytes are right-aligned: the first byte sits in the most significant used position
   task automatic load(input logic [19:0] base, input int n, input logic [191:0] bytes);
      for (int k = 0; k < n; k++) poke(base + 20'(k), bytes[8*(n-1-k) +: 8]);
   endtask

   task automatic rd(input logic [19:0] ad);
      exp_q.push_back({1'b0, ad, 8'h00});
   endtask

   task automatic wr(input logic [19:0] ad, input logic [7:0] d);
      exp_q.push_back({1'b1, ad, d});
   endtask

   task automatic do_reset();
      ce = 1'b1;
      @(negedge clock);
      chk("rst_w0", 32'(w), 32'h0);
      @(negedge clock);
      chk("rst_w1", 32'(w), 32'h0);
      chk("rst_a", 32'(a), 32'h00100);
      chk("rst_o", 32'(o), 32'h00);
      reset_n = 1'b0;
   endtask

   function automatic logic [28:0] bus_now();
      return {w, a, (w ? o : 8'h00)};
   endfunction

   task automatic drain(input string name, input int drop_at, input int raise_at,
                        input logic [7:0] vec2, input bit stall);
      logic [28:0] e;
      int n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("%s_c%0d", name, n), 32'(bus_now()), 32'(e));
         if (n == drop_at)  intr = 1'b0;
         if (n == raise_at) begin intr = 1'b1; intn = vec2; end
         if (stall && $urandom_range(0, 3) == 0) begin
            ce = 1'b0;
            @(negedge clock);
            chk($sformatf("%s_hold%0d", name, n), 32'(bus_now()), 32'(e));
            ce = 1'b1;
         end
         @(negedge clock);
         n++;
      end
   endtask

   initial begin
      reset_n = 1'b1; ce = 1'b1; intr = 1'b0; intn = 8'h00;
      tb_we = 1'b0; tb_addr = '0; tb_data = '0;

      // MOV AX,1234h; MOV [0200h],AL; PUSH AX; JMP $
      load(20'h00100, 9, 192'hB83412_A20002_50_EBFE);
      do_reset();
      rd(20'h00100); rd(20'h00101); rd(20'h00102); rd(20'h00103);
      rd(20'h00103); rd(20'h00104); rd(20'h00105); wr(20'h00200, 8'h34); rd(20'h00106);
      rd(20'h00106); wr(20'h0FFFF, 8'h12); wr(20'h0FFFE, 8'h34); rd(20'h00107);
      rd(20'h00107); rd(20'h00108); rd(20'h00109);
      rd(20'h00107); rd(20'h00108); rd(20'h00109); rd(20'h00107);
      drain("mov", -1, -1, 8'h00, 1'b0);
      chk("mem200", 32'(mem[20'h00200]), 32'h34);

      // stack, POP, INC/DEC flags, JZ/JNZ, MOV AH, with random clock-enable stalls
      reset_n = 1'b1;
      load(20'h00100, 22, 192'hBC0010_B83412_50_5B_B9FFFF_41_7402_F4F4_49_B456_50_75FE);
      do_reset();
      rd(20'h00100); rd(20'h00101); rd(20'h00102); rd(20'h00103);
      rd(20'h00103); rd(20'h00104); rd(20'h00105); rd(20'h00106);
      rd(20'h00106); wr(20'h00FFF, 8'h12); wr(20'h00FFE, 8'h34); rd(20'h00107);
      rd(20'h00107); rd(20'h00FFE); rd(20'h00FFF); rd(20'h00108);
      rd(20'h00108); rd(20'h00109); rd(20'h0010A); rd(20'h0010B);
      rd(20'h0010B); rd(20'h0010C);
      rd(20'h0010C); rd(20'h0010D); rd(20'h0010E);
      rd(20'h00110); rd(20'h00111);
      rd(20'h00111); rd(20'h00112); rd(20'h00113);
      rd(20'h00113); wr(20'h00FFF, 8'h56); wr(20'h00FFE, 8'h34); rd(20'h00114);
      rd(20'h00114); rd(20'h00115); rd(20'h00116); rd(20'h00114);
      drain("stk", -1, -1, 8'h00, 1'b1);

      // intr masked, then STI takes it; IRET; HLT woken by intr
      reset_n = 1'b1;
      load(20'h00100, 3, 192'h90_FB_F4);
      load(20'h00400, 1, 192'hCF);
      load(20'h00500, 2, 192'hEBFE);
      load(20'h0000C, 4, 192'h0003_1000);
      load(20'h00080, 4, 192'h0005_0000);
      intr = 1'b1; intn = 8'h03;
      do_reset();
      rd(20'h00100); rd(20'h00101); rd(20'h00101); rd(20'h00102);
      wr(20'h0FFFF, 8'h02); wr(20'h0FFFE, 8'h02); wr(20'h0FFFD, 8'h00);
      wr(20'h0FFFC, 8'h00); wr(20'h0FFFB, 8'h01); wr(20'h0FFFA, 8'h02);
      rd(20'h0000C); rd(20'h0000D); rd(20'h0000E); rd(20'h0000F); rd(20'h00400);
      rd(20'h00400); rd(20'h0FFFA); rd(20'h0FFFB); rd(20'h0FFFC); rd(20'h0FFFD);
      rd(20'h0FFFE); rd(20'h0FFFF); rd(20'h00102);
      rd(20'h00102); rd(20'h00103); rd(20'h00103); rd(20'h00103);
      wr(20'h0FFFF, 8'h02); wr(20'h0FFFE, 8'h02); wr(20'h0FFFD, 8'h00);
      wr(20'h0FFFC, 8'h00); wr(20'h0FFFB, 8'h01); wr(20'h0FFFA, 8'h03);
      rd(20'h00080); rd(20'h00081); rd(20'h00082); rd(20'h00083); rd(20'h00500);
      rd(20'h00500); rd(20'h00501); rd(20'h00502); rd(20'h00500);
      drain("irq", 14, 26, 8'h20, 1'b0);
      intr = 1'b0;

      // MOV AL,[0300h]; INT 21h; handler pushes AX
      reset_n = 1'b1;
      load(20'h00100, 5, 192'hA00003_CD21);
      load(20'h00300, 1, 192'h5A);
      load(20'h00084, 4, 192'h0006_0000);
      load(20'h00600, 3, 192'h50_EBFE);
      do_reset();
      rd(20'h00100); rd(20'h00101); rd(20'h00102); rd(20'h00300); rd(20'h00103);
      rd(20'h00103); rd(20'h00104);
      wr(20'h0FFFF, 8'h00); wr(20'h0FFFE, 8'h02); wr(20'h0FFFD, 8'h00);
      wr(20'h0FFFC, 8'h00); wr(20'h0FFFB, 8'h01); wr(20'h0FFFA, 8'h05);
      rd(20'h00084); rd(20'h00085); rd(20'h00086); rd(20'h00087); rd(20'h00600);
      rd(20'h00600); wr(20'h0FFF9, 8'h00); wr(20'h0FFF8, 8'h5A); rd(20'h00601);
      rd(20'h00601); rd(20'h00602); rd(20'h00603); rd(20'h00601);
      drain("int", -1, -1, 8'h00, 1'b1);

      // reset landing on the second byte of a PUSH must not write
      reset_n = 1'b1;
      load(20'h00100, 1, 192'h50);
      poke(20'h0FFFF, 8'hA5);
      poke(20'h0FFFE, 8'hA5);
      do_reset();
      rd(20'h00100); wr(20'h0FFFF, 8'h00);
      drain("abort", -1, -1, 8'h00, 1'b0);
      reset_n = 1'b1;
      #1;
      chk("abort_w", 32'(w), 32'h0);
      @(negedge clock);
      chk("abort_mffff", 32'(mem[20'h0FFFF]), 32'h00);
      chk("abort_mfffe", 32'(mem[20'h0FFFE]), 32'hA5);
      chk("abort_a", 32'(a), 32'h00100);
      do_reset();
      rd(20'h00100); wr(20'h0FFFF, 8'h00);
      drain("restart", -1, -1, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
